phase_comp_early_late: RTL and testbench
========================================

PHASE_COMP_EARLY_LATE -- requirements
Module: phase_comp_early_late

Interface
REQ-001 Parameter WIN, default 16: valid samples per vote window, power of two, 4..64.
REQ-002 Parameter THRESH, default 2: vote magnitude strictly exceeded to issue an adjustment.
REQ-003 Parameter HOLDOFF, default 1: windows whose result is discarded after an adjustment.
REQ-004 Parameter LOCK_WIN, default 4: consecutive quiet windows before lock is asserted.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 smp_valid  input  1  data_smp and edge_smp are valid this cycle.
REQ-008 data_smp  input  1  data-centre sample for the current bit.
REQ-009 edge_smp  input  1  edge sample taken between the previous bit and the current bit.
REQ-010 adj_valid  output  1  one-cycle pulse that qualifies down; feeds the 2-bit phase adder.
REQ-011 down  output  1  1 = decrement phase code, 0 = increment; held until the next adj_valid.
REQ-012 locked  output  1  loop quiet for LOCK_WIN windows.

Function
REQ-013 Block SHALL hold a previous-bit register d_prev and a flag prev_ok, set by the first accepted sample.
REQ-014 Each cycle with smp_valid=1 and prev_ok=1 SHALL be classified as follows:
- d_prev==data_smp: none (0).
- edge_smp==data_smp: late (-1).
- otherwise: early (+1).
REQ-015 A sample accepted with prev_ok=0 SHALL count toward the window and SHALL vote 0.
REQ-016 Cycles with smp_valid=0 SHALL leave all state unchanged.
REQ-017 Vote accumulator SHALL be signed, clog2(WIN)+2 bits wide, and saturate at +/-WIN.
REQ-018 Sample counter SHALL count accepted samples 0..WIN-1 and wrap to 0.
REQ-019 The window's last sample SHALL be included in the sum before the decision.
REQ-020 At window end, the accumulator SHALL clear to 0 on the same edge.
REQ-021 Decision SHALL be registered; adj_valid rises exactly 1 cycle after the clk edge accepting the last sample.
REQ-022 Decision outcomes SHALL be:
- sum > THRESH: down=0 with adj_valid.
- sum < -THRESH: down=1 with adj_valid.
- otherwise: no pulse and down unchanged.
REQ-023 After an adjustment, the next HOLDOFF window results SHALL produce no pulse.
REQ-024 Windows discarded under REQ-023 SHALL count neither as quiet nor as adjustments.
REQ-025 Holdoff state machine SHALL have states RUN and HOLD:
- RUN->HOLD on an adjustment when HOLDOFF>0.
- HOLD->RUN after HOLDOFF window ends.
REQ-026 Quiet counter SHALL increment on each RUN window without an adjustment and saturate at LOCK_WIN.
REQ-027 locked SHALL assert when the quiet count reaches LOCK_WIN.
REQ-028 Any adjustment SHALL clear the quiet count and deassert locked on the same cycle adj_valid asserts.
REQ-029 adj_valid SHALL never assert on two consecutive cycles.

Reset
REQ-030 rst_n low SHALL asynchronously force the following, regardless of in-progress window:
- adj_valid=0, down=0, locked=0.
- accumulator=0, counters=0.
- prev_ok=0, state=RUN.
REQ-031 Release SHALL be synchronous to clk; the first sample after release is treated per REQ-015.

Structure
REQ-032 Shared package phase_comp_pkg SHALL hold:
- parameter defaults;
- vote encoding constants VOTE_EARLY/VOTE_LATE/VOTE_NONE;
- the RUN/HOLD state enum.
REQ-033 Combinational sub-module phase_comp_el_classify SHALL implement REQ-014.
REQ-034 The remainder SHALL be in phase_comp_early_late.

Verification
REQ-035 Defaults; 16 samples of alternating data, edge_smp equal to previous bit -> one adj_valid, down=0, sum=+15.
REQ-036 Defaults; 16 samples of alternating data, edge_smp equal to current bit -> adj_valid, down=1.
REQ-037 Defaults; next window after an adjustment is also all late -> no pulse (holdoff); the following all-late window pulses down=1.
REQ-038 Defaults; windows of constant data -> no pulses; locked rises at the 4th window end; one early window -> locked falls when adj_valid=1.
REQ-039 Defaults; sum exactly +2 or -2 -> no pulse; sum +3 -> pulse.
REQ-040 Defaults; rst_n dropped mid-window after 9 late samples, then released -> outputs 0 immediately; the next full window alone decides.

Source files
------------

// File: rtl/phase_comp_pkg.sv
// Shared defaults, vote encoding and holdoff state type
// for the early/late phase comparator.
package phase_comp_pkg;

    localparam int WIN_DEF      = 16;
    localparam int THRESH_DEF   = 2;
    localparam int HOLDOFF_DEF  = 1;
    localparam int LOCK_WIN_DEF = 4;

    localparam logic signed [1:0] VOTE_NONE  = 2'sb00;
    localparam logic signed [1:0] VOTE_EARLY = 2'sb01;
    localparam logic signed [1:0] VOTE_LATE  = 2'sb11;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/phase_comp_el_classify.sv
// Bang-bang early/late classifier for one bit transition.
// Purely combinational; no vote without a valid previous bit.
module phase_comp_el_classify
    import phase_comp_pkg::*;
(
    input  logic              prev_ok,
    input  logic              d_prev,
    input  logic              data_smp,
    input  logic              edge_smp,
    output logic signed [1:0] vote
);

    always_comb begin
        vote = VOTE_NONE;
        if (!prev_ok) begin
            vote = VOTE_NONE;
        end else if (d_prev == data_smp) begin
            vote = VOTE_NONE;
        end else if (edge_smp == data_smp) begin
            vote = VOTE_LATE;
        end else begin
            vote = VOTE_EARLY;
        end
    end

endmodule

// File: rtl/phase_comp_early_late.sv
// Windowed early/late vote accumulator with registered decision,
// post-adjustment holdoff and quiet-window lock detection.
module phase_comp_early_late
    import phase_comp_pkg::*;
#(
    parameter int WIN      = WIN_DEF,
    parameter int THRESH   = THRESH_DEF,
    parameter int HOLDOFF  = HOLDOFF_DEF,
    parameter int LOCK_WIN = LOCK_WIN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic smp_valid,
    input  logic data_smp,
    input  logic edge_smp,
    output logic adj_valid,
    output logic down,
    output logic locked
);

    localparam int AW = $clog2(WIN) + 2;
    localparam int CW = $clog2(WIN);
    localparam int QW = $clog2(LOCK_WIN + 2);
    localparam int HW = $clog2(HOLDOFF + 2);

    localparam logic signed [AW-1:0] SMAX = AW'(WIN);
    localparam logic signed [AW-1:0] SMIN = -SMAX;
    localparam logic signed [AW-1:0] TPOS = AW'(THRESH);
    localparam logic signed [AW-1:0] TNEG = -TPOS;

    logic              d_prev_q, d_prev_d;
    logic              prev_ok_q, prev_ok_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [QW-1:0]     quiet_q, quiet_d;
    logic [HW-1:0]     hold_q, hold_d;
    state_t            state_q, state_d;
    logic              adj_valid_q, adj_valid_d;
    logic              down_q, down_d;
    logic              locked_q, locked_d;

    logic signed [1:0]    vote;
    logic signed [AW-1:0] sum_raw;
    logic signed [AW-1:0] sum;
    logic                 win_end;

    phase_comp_el_classify u_classify (
        .prev_ok  (prev_ok_q),
        .d_prev   (d_prev_q),
        .data_smp (data_smp),
        .edge_smp (edge_smp),
        .vote     (vote)
    );

    always_comb begin
        d_prev_d    = d_prev_q;
        prev_ok_d   = prev_ok_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        quiet_d     = quiet_q;
        hold_d      = hold_q;
        state_d     = state_q;
        adj_valid_d = 1'b0;
        down_d      = down_q;

        sum_raw = acc_q + {{(AW-2){vote[1]}}, vote};
        sum     = sum_raw;
        if (sum_raw > SMAX) begin
            sum = SMAX;
        end else if (sum_raw < SMIN) begin
            sum = SMIN;
        end

        win_end = smp_valid && (cnt_q == CW'(WIN - 1));

        if (smp_valid) begin
            d_prev_d  = data_smp;
            prev_ok_d = 1'b1;
            cnt_d     = cnt_q + 1'b1;
            acc_d     = win_end ? '0 : sum;
        end

        // Decide on the sum that already includes this last sample
        if (win_end) begin
            if (state_q == HOLD) begin
                if (hold_q == HW'(HOLDOFF - 1)) begin
                    state_d = RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end else if (sum > TPOS || sum < TNEG) begin
                adj_valid_d = 1'b1;
                down_d      = (sum < TNEG);
                quiet_d     = '0;
                if (HOLDOFF > 0) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end else if (quiet_q != QW'(LOCK_WIN)) begin
                quiet_d = quiet_q + 1'b1;
            end
        end

        locked_d = (quiet_d == QW'(LOCK_WIN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_prev_q    <= 1'b0;
            prev_ok_q   <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            quiet_q     <= '0;
            hold_q      <= '0;
            state_q     <= RUN;
            adj_valid_q <= 1'b0;
            down_q      <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            d_prev_q    <= d_prev_d;
            prev_ok_q   <= prev_ok_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            quiet_q     <= quiet_d;
            hold_q      <= hold_d;
            state_q     <= state_d;
            adj_valid_q <= adj_valid_d;
            down_q      <= down_d;
            locked_q    <= locked_d;
        end
    end

    assign adj_valid = adj_valid_q;
    assign down      = down_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_phase_comp_early_late.sv
// Self-checking bench for phase_comp_early_late: window table,
// hand-written corner sequences and random traffic vs a model.
module tb_phase_comp_early_late;

    localparam int WIN      = 16;
    localparam int THRESH   = 2;
    localparam int HOLDOFF  = 1;
    localparam int LOCK_WIN = 4;

    localparam int K_CONST = 0;
    localparam int K_EARLY = 1;
    localparam int K_LATE  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic smp_valid = 1'b0;
    logic data_smp = 1'b0;
    logic edge_smp = 1'b0;
    logic adj_valid, down, locked;

    int n_cmp = 0;
    int n_bad = 0;

    phase_comp_early_late #(
        .WIN(WIN), .THRESH(THRESH), .HOLDOFF(HOLDOFF), .LOCK_WIN(LOCK_WIN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .smp_valid (smp_valid),
        .data_smp  (data_smp),
        .edge_smp  (edge_smp),
        .adj_valid (adj_valid),
        .down      (down),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    // Reference model: per-window list of votes, holdoff as a countdown
    bit m_prev, m_ok;
    int votes[$];
    int m_hold, m_quiet;
    bit e_adj, e_down, e_lock;
    bit cur;

    task automatic model_reset();
        m_prev = 0; m_ok = 0; votes.delete();
        m_hold = 0; m_quiet = 0;
        e_adj = 0; e_down = 0; e_lock = 0;
    endtask

    task automatic model_accept(input bit d, input bit e);
        int v;
        int s;
        if (!m_ok) v = 0;
        else if (m_prev == d) v = 0;
        else if (e == d) v = -1;
        else v = 1;
        votes.push_back(v);
        m_prev = d;
        m_ok = 1;
        if (votes.size() == WIN) begin
            s = 0;
            foreach (votes[i]) begin
                s += votes[i];
                if (s > WIN) s = WIN;
                if (s < -WIN) s = -WIN;
            end
            votes.delete();
            if (m_hold > 0) begin
                m_hold--;
            end else if (s > THRESH || s < -THRESH) begin
                e_adj = 1;
                e_down = (s < 0);
                m_quiet = 0;
                m_hold = HOLDOFF;
            end else if (m_quiet < LOCK_WIN) begin
                m_quiet++;
            end
            e_lock = (m_quiet >= LOCK_WIN);
        end
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit v, input bit d, input bit e);
        smp_valid = v;
        data_smp = d;
        edge_smp = e;
        @(posedge clk);
        #1;
        e_adj = 0;
        if (v) model_accept(d, e);
        check("adj_valid", adj_valid, e_adj);
        check("down", down, e_down);
        check("locked", locked, e_lock);
    endtask

    task automatic send(input int kind, input int n, input bit gaps);
        bit nd, ne;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0)
                step(1'b0, 1'($urandom), 1'($urandom));
            case (kind)
                K_EARLY: begin nd = ~cur; ne = cur; end
                K_LATE:  begin nd = ~cur; ne = nd; end
                default: begin nd = cur; ne = 1'($urandom); end
            endcase
            step(1'b1, nd, ne);
            cur = nd;
        end
    endtask

    task automatic send_win(input int ne, input int nl);
        send(K_CONST, WIN - ne - nl, 1'b0);
        send(K_EARLY, ne, 1'b0);
        send(K_LATE, nl, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        smp_valid = 1'b0;
        #1;
        check("rst_adj_valid", adj_valid, 1'b0);
        check("rst_down", down, 1'b0);
        check("rst_locked", locked, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int n_early;
        int n_late;
        bit x_adj;
        bit x_down;
        bit x_lock;
    } win_vec_t;

    win_vec_t tbl[9];

    initial begin
        tbl[0] = '{16, 0, 1, 0, 0};
        tbl[1] = '{0, 16, 0, 0, 0};
        tbl[2] = '{0, 16, 1, 1, 0};
        tbl[3] = '{0, 0, 0, 1, 0};
        tbl[4] = '{0, 0, 0, 1, 0};
        tbl[5] = '{0, 0, 0, 1, 0};
        tbl[6] = '{0, 0, 0, 1, 0};
        tbl[7] = '{0, 0, 0, 1, 1};
        tbl[8] = '{16, 0, 1, 0, 0};

        cur = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 9; i++) begin
            send_win(tbl[i].n_early, tbl[i].n_late);
            check($sformatf("tbl%0d_adj", i), adj_valid, tbl[i].x_adj);
            check($sformatf("tbl%0d_down", i), down, tbl[i].x_down);
            check($sformatf("tbl%0d_lock", i), locked, tbl[i].x_lock);
            step(1'b0, 1'b0, 1'b0);
            check($sformatf("tbl%0d_no_repeat", i), adj_valid, 1'b0);
        end

        // Threshold boundary: +2 and -2 quiet, +3 adjusts
        do_reset();
        send_win(2, 0);
        check("sum_p2_adj", adj_valid, 1'b0);
        send_win(0, 2);
        check("sum_m2_adj", adj_valid, 1'b0);
        send_win(3, 0);
        check("sum_p3_adj", adj_valid, 1'b1);
        check("sum_p3_down", down, 1'b0);

        // Reset mid-window after 9 late samples
        do_reset();
        send_win(0, 16);
        check("pre_rst_down", down, 1'b1);
        send(K_LATE, 9, 1'b0);
        do_reset();
        send_win(16, 0);
        check("post_rst_adj", adj_valid, 1'b1);
        check("post_rst_down", down, 1'b0);

        // Random traffic in mixed-mode segments with valid gaps
        do_reset();
        for (int seg = 0; seg < 150; seg++) begin
            int mode;
            mode = $urandom_range(0, 4);
            if (mode == 4) begin
                for (int i = 0; i < 20; i++)
                    step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
                cur = m_prev;
            end else begin
                send(mode, $urandom_range(4, 24), 1'b1);
            end
            if ($urandom_range(0, 40) == 0) begin
                do_reset();
                cur = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
